// File: rtl/mem_arbiter_pkg.sv
// Shared types for the instruction/data memory arbiter.
package mem_arbiter_pkg;

  typedef logic [63:0] addr_t;
  typedef logic [31:0] word_t;
  typedef logic [63:0] dword_t;

  typedef enum logic [1:0] {FREE, BUSY, ACCESS, ERROR} ramstate_t;
  typedef enum logic [1:0] {IDLE, I_WAIT, D_WAIT} arb_state_t;

  localparam int MAX_D_STREAK_DEF = 4;
  localparam int STREAK_W_DEF     = 3;

  // Pick the 32-bit instruction word out of a 64-bit RAM line.
  function automatic word_t sel_word(input logic hi, input dword_t line);
    return hi ? line[63:32] : line[31:0];
  endfunction

endpackage

// File: rtl/mem_arb_if.sv
// Bundle of all arbiter-facing signals; the arbiter and bench views differ only in direction.
interface mem_arb_if;
  import mem_arbiter_pkg::*;

  logic      CLK;
  logic      RST;
  logic      iREN;
  addr_t     iaddr;
  logic      ihit;
  word_t     iload;
  logic      dREN;
  logic      dWEN;
  addr_t     daddr;
  dword_t    dstore;
  logic      dhit;
  dword_t    dload;
  logic      mem_err;
  logic      ram_ren;
  logic      ram_wen;
  addr_t     ram_addr;
  dword_t    ram_store;
  dword_t    ram_load;
  ramstate_t ram_state;

  modport arb (
    input  CLK, RST, iREN, iaddr, dREN, dWEN, daddr, dstore, ram_load, ram_state,
    output ihit, iload, dhit, dload, mem_err, ram_ren, ram_wen, ram_addr, ram_store
  );

  modport tb (
    output CLK, RST, iREN, iaddr, dREN, dWEN, daddr, dstore, ram_load, ram_state,
    input  ihit, iload, dhit, dload, mem_err, ram_ren, ram_wen, ram_addr, ram_store
  );

endinterface

// File: rtl/mem_arbiter_priority.sv
// Grant decision: data wins unless an instruction fetch has waited through a full data streak.
module arb_priority #(
  parameter int MAX_D_STREAK = 4,
  parameter int STREAK_W     = 3
) (
  input  logic                d_req,
  input  logic                i_req,
  input  logic [STREAK_W-1:0] streak,
  output logic                grant_d,
  output logic                grant_i
);

  logic i_due;

  assign i_due   = i_req && (streak == STREAK_W'(MAX_D_STREAK));
  assign grant_d = d_req && !i_due;
  assign grant_i = !grant_d && i_req;

endmodule

// File: rtl/mem_arbiter.sv
// Single-outstanding arbiter of IF fetch and MEM data ports onto one RAM port.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int MAX_D_STREAK = MAX_D_STREAK_DEF,
  parameter int STREAK_W     = STREAK_W_DEF
) (
  input  logic      CLK,
  input  logic      RST,
  input  logic      iREN,
  input  addr_t     iaddr,
  output logic      ihit,
  output word_t     iload,
  input  logic      dREN,
  input  logic      dWEN,
  input  addr_t     daddr,
  input  dword_t    dstore,
  output logic      dhit,
  output dword_t    dload,
  output logic      mem_err,
  output logic      ram_ren,
  output logic      ram_wen,
  output addr_t     ram_addr,
  output dword_t    ram_store,
  input  dword_t    ram_load,
  input  ramstate_t ram_state
);

  arb_state_t          state;
  logic [STREAK_W-1:0] streak;
  logic [63:2]         i_addr_lat;   // byte offset within the word is irrelevant
  addr_t               d_addr_lat;
  dword_t              d_store_lat;
  logic                d_wr_lat;
  logic                grant_d, grant_i;
  logic                unused_ibits;

  assign unused_ibits = ^iaddr[1:0];

  arb_priority #(
    .MAX_D_STREAK (MAX_D_STREAK),
    .STREAK_W     (STREAK_W)
  ) u_prio (
    .d_req   (dREN | dWEN),
    .i_req   (iREN),
    .streak  (streak),
    .grant_d (grant_d),
    .grant_i (grant_i)
  );

  // RAM port is driven only from latched request state, so input wiggles mid-wait never reach it.
  always_comb begin
    ram_ren   = 1'b0;
    ram_wen   = 1'b0;
    ram_addr  = '0;
    ram_store = '0;
    case (state)
      I_WAIT: begin
        ram_ren  = 1'b1;
        ram_addr = {i_addr_lat[63:3], 3'b000};
      end
      D_WAIT: begin
        ram_ren   = !d_wr_lat;
        ram_wen   = d_wr_lat;
        ram_addr  = d_addr_lat;
        ram_store = d_store_lat;
      end
      default: ;
    endcase
  end

  // Arbitration FSM with registered hit/error pulses and load data.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= IDLE;
      streak      <= '0;
      i_addr_lat  <= '0;
      d_addr_lat  <= '0;
      d_store_lat <= '0;
      d_wr_lat    <= 1'b0;
      ihit        <= 1'b0;
      dhit        <= 1'b0;
      mem_err     <= 1'b0;
      iload       <= '0;
      dload       <= '0;
    end else begin
      ihit    <= 1'b0;
      dhit    <= 1'b0;
      mem_err <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_d) begin
            d_addr_lat  <= daddr;
            d_store_lat <= dstore;
            d_wr_lat    <= dWEN;
            state       <= D_WAIT;
            if (streak != STREAK_W'(MAX_D_STREAK)) streak <= streak + 1'b1;
          end else begin
            // Either nothing from the data side or the fetch has been let through.
            streak <= '0;
            if (grant_i) begin
              i_addr_lat <= iaddr[63:2];
              state      <= I_WAIT;
            end
          end
        end
        I_WAIT: begin
          if (ram_state == ERROR) begin
            mem_err <= 1'b1;
            state   <= IDLE;
          end else if (ram_state == ACCESS) begin
            ihit  <= iREN;
            iload <= sel_word(i_addr_lat[2], ram_load);
            state <= IDLE;
          end else if (!iREN) begin
            state <= IDLE;   // fetch flushed
          end
        end
        D_WAIT: begin
          if (ram_state == ERROR) begin
            mem_err <= 1'b1;
            state   <= IDLE;
          end else if (ram_state == ACCESS) begin
            if (d_wr_lat) begin
              dhit <= dWEN;   // write lands regardless; only the handshake is dropped
            end else begin
              dhit  <= dREN;
              dload <= ram_load;
            end
            state <= IDLE;
          end else if (!d_wr_lat && !dREN) begin
            state <= IDLE;   // reads may be abandoned, writes may not
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter; the RAM is played by the stimulus itself.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  mem_arb_if b();

  int n_chk  = 0;
  int n_pass = 0;

  mem_arbiter u_dut (
    .CLK       (b.CLK),
    .RST       (b.RST),
    .iREN      (b.iREN),
    .iaddr     (b.iaddr),
    .ihit      (b.ihit),
    .iload     (b.iload),
    .dREN      (b.dREN),
    .dWEN      (b.dWEN),
    .daddr     (b.daddr),
    .dstore    (b.dstore),
    .dhit      (b.dhit),
    .dload     (b.dload),
    .mem_err   (b.mem_err),
    .ram_ren   (b.ram_ren),
    .ram_wen   (b.ram_wen),
    .ram_addr  (b.ram_addr),
    .ram_store (b.ram_store),
    .ram_load  (b.ram_load),
    .ram_state (b.ram_state)
  );

  initial b.CLK = 1'b0;
  always #5 b.CLK = ~b.CLK;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Advance one clock; outputs are sampled and inputs changed 1 time unit after the edge.
  task automatic tick();
    @(posedge b.CLK);
    #1;
  endtask

  initial begin
    logic       is_i;
    logic [5:0] order;
    dword_t     ld;
    dword_t     last_d;

    b.RST = 1'b1; b.iREN = 1'b0; b.iaddr = '0; b.dREN = 1'b0; b.dWEN = 1'b0;
    b.daddr = '0; b.dstore = '0; b.ram_load = '0; b.ram_state = FREE;
    last_d = '0;
    tick(); tick();
    chk("rst pulses",  64'({b.ihit, b.dhit, b.mem_err, b.ram_ren, b.ram_wen}), 64'd0);
    chk("rst iload",   64'(b.iload), 64'd0);
    chk("rst dload",   b.dload, 64'd0);
    chk("rst ramaddr", b.ram_addr, 64'd0);
    b.RST = 1'b0;

    // 1: fetch at 0x1004, upper word selected, RAM addr aligned
    b.iREN = 1'b1; b.iaddr = 64'h1004;
    tick();
    chk("t1 ren",  64'(b.ram_ren), 64'd1);
    chk("t1 addr", b.ram_addr, 64'h1000);
    b.ram_state = BUSY;
    tick();
    chk("t1 nohit", 64'(b.ihit), 64'd0);
    chk("t1 addr2", b.ram_addr, 64'h1000);
    b.ram_state = ACCESS; b.ram_load = 64'hAAAA_BBBB_CCCC_DDDD;
    tick();
    chk("t1 ihit",  64'(b.ihit), 64'd1);
    chk("t1 iload", 64'(b.iload), 64'hAAAA_BBBB);
    chk("t1 idle",  64'(b.ram_ren), 64'd0);
    b.iREN = 1'b0; b.ram_state = FREE;
    tick();
    chk("t1 pulse", 64'(b.ihit), 64'd0);

    // 2: both ports busy -> D,D,D,D,I,D
    order = 6'b010000;   // bit k set = instruction expected on grant k
    b.iREN = 1'b1; b.iaddr = 64'h40; b.dREN = 1'b1; b.daddr = 64'h3000;
    tick();
    for (int k = 0; k < 6; k++) begin
      is_i = order[k];
      chk("t2 addr", b.ram_addr, is_i ? 64'h40 : 64'h3000);
      b.ram_state = BUSY;
      tick();
      ld = {32'hA000_0000 | 32'(k), 32'hB000_0000 | 32'(k)};
      b.ram_state = ACCESS; b.ram_load = ld;
      tick();
      chk("t2 hit", 64'({b.ihit, b.dhit}), is_i ? 64'd2 : 64'd1);
      if (is_i) chk("t2 iload", 64'(b.iload), 64'(ld[31:0]));
      else begin
        chk("t2 dload", b.dload, ld);
        last_d = ld;
      end
      b.ram_state = FREE;
      if (k == 5) begin b.iREN = 1'b0; b.dREN = 1'b0; end
      tick();
    end
    chk("t2 quiet", 64'({b.ram_ren, b.ram_wen}), 64'd0);

    // 3: write dropped after grant still runs to ACCESS, silently
    b.dWEN = 1'b1; b.daddr = 64'h2008; b.dstore = 64'h1234;
    tick();
    chk("t3 en",    64'({b.ram_ren, b.ram_wen}), 64'd1);
    chk("t3 addr",  b.ram_addr, 64'h2008);
    chk("t3 store", b.ram_store, 64'h1234);
    b.dWEN = 1'b0; b.ram_state = BUSY;
    tick();
    chk("t3 held",  64'(b.ram_wen), 64'd1);
    b.ram_state = ACCESS;
    tick();
    chk("t3 nohit", 64'(b.dhit), 64'd0);
    chk("t3 dload", b.dload, last_d);
    chk("t3 off",   64'({b.ram_ren, b.ram_wen}), 64'd0);
    b.ram_state = FREE;
    tick();
    chk("t3 off2",  64'({b.ram_ren, b.ram_wen}), 64'd0);

    // 4: fetch flushed while RAM busy, then a clean fetch of 0x0
    b.iREN = 1'b1; b.iaddr = 64'h500;
    tick();
    chk("t4 ren", 64'(b.ram_ren), 64'd1);
    b.iREN = 1'b0; b.ram_state = BUSY;
    tick();
    chk("t4 abort", 64'({b.ram_ren, b.ihit}), 64'd0);
    b.ram_state = FREE;
    tick();
    chk("t4 nohit", 64'(b.ihit), 64'd0);
    b.iREN = 1'b1; b.iaddr = 64'h0;
    tick();
    chk("t4 addr", b.ram_addr, 64'h0);
    b.ram_state = ACCESS; b.ram_load = 64'hDEAD_BEEF_CAFE_F00D;
    tick();
    chk("t4 ihit",  64'(b.ihit), 64'd1);
    chk("t4 iload", 64'(b.iload), 64'hCAFE_F00D);
    b.iREN = 1'b0; b.ram_state = FREE;
    tick();

    // 5: RAM error on a read -> mem_err once, retry, then complete
    b.dREN = 1'b1; b.daddr = 64'h3008;
    tick();
    b.ram_state = ERROR; b.ram_load = 64'hFFFF_FFFF_FFFF_FFFF;
    tick();
    chk("t5 err",   64'({b.mem_err, b.dhit}), 64'd2);
    chk("t5 dload", b.dload, last_d);
    chk("t5 idle",  64'(b.ram_ren), 64'd0);
    b.ram_state = FREE;
    tick();
    chk("t5 once",  64'(b.mem_err), 64'd0);
    chk("t5 regnt", 64'(b.ram_ren), 64'd1);
    chk("t5 addr",  b.ram_addr, 64'h3008);
    b.ram_state = ACCESS; b.ram_load = 64'h5555;
    tick();
    chk("t5 dhit",  64'(b.dhit), 64'd1);
    chk("t5 dload2", b.dload, 64'h5555);
    b.dREN = 1'b0; b.ram_state = FREE;
    tick();

    // 6: reset mid data wait, then immediate fetch grant (upper word)
    b.dREN = 1'b1; b.daddr = 64'h4000;
    tick();
    chk("t6 ren", 64'(b.ram_ren), 64'd1);
    b.RST = 1'b1; b.ram_state = BUSY;
    tick();
    chk("t6 pulses", 64'({b.ihit, b.dhit, b.mem_err, b.ram_ren, b.ram_wen}), 64'd0);
    chk("t6 addr",   b.ram_addr, 64'd0);
    chk("t6 dload",  b.dload, 64'd0);
    chk("t6 iload",  64'(b.iload), 64'd0);
    b.RST = 1'b0; b.dREN = 1'b0; b.iREN = 1'b1; b.iaddr = 64'hC; b.ram_state = FREE;
    tick();
    chk("t6 grant", 64'(b.ram_ren), 64'd1);
    chk("t6 iaddr", b.ram_addr, 64'h8);
    b.ram_state = ACCESS; b.ram_load = 64'h1122_3344_5566_7788;
    tick();
    chk("t6 ihit",  64'(b.ihit), 64'd1);
    chk("t6 iload2", 64'(b.iload), 64'h1122_3344);
    b.iREN = 1'b0; b.ram_state = FREE;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
